// File: rtl/comb_seq_pkg.sv
// comb_seq_pkg: shared FSM type, vector count and Gray helper for the vector sequencer
package comb_seq_pkg;
  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CHECK, DONE} state_t;
  localparam int NUM_VEC = 16;
  function automatic logic [3:0] gray4(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction
endpackage

// File: rtl/comb_vector_sequencer_if.sv
// comb_vector_sequencer_if: control, truth-table and datapath signals between sequencer and its user
interface comb_vector_sequencer_if;
  logic start_i, mode_i, y_i;
  logic [15:0] expected_i;
  logic a_o, b_o, c_o, d_o;
  logic busy_o, done_o, first_err_valid_o;
  logic [4:0] err_cnt_o, glitch_cnt_o;
  logic [3:0] first_err_vec_o;
  modport master (
    output start_i, mode_i, expected_i, y_i,
    input a_o, b_o, c_o, d_o, busy_o, done_o, err_cnt_o, glitch_cnt_o, first_err_vec_o, first_err_valid_o
  );
  modport slave (
    input start_i, mode_i, expected_i, y_i,
    output a_o, b_o, c_o, d_o, busy_o, done_o, err_cnt_o, glitch_cnt_o, first_err_vec_o, first_err_valid_o
  );
endinterface

// File: rtl/comb_vector_sequencer.sv
// comb_vector_sequencer: walks all 16 vectors through a 4-input comb block and scores y
module comb_vector_sequencer
  import comb_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input logic clk,
  input logic rst_n,
  comb_vector_sequencer_if.slave bus
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [3:0] LAST_IDX = 4'(NUM_VEC - 1);
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("SETTLE_CYCLES must be at least 1");
  end
  state_t state, state_n;
  logic mode_q, pend, y_prev, fvalid, miss;
  logic [15:0] exp_q;
  logic [3:0] idx, idx_n, vec, fvec;
  logic [1:0] tcnt;
  logic [CW-1:0] scnt;
  logic [4:0] err_cnt, glitch_cnt;
  assign idx_n = idx + 4'd1;
  assign miss = bus.y_i != exp_q[vec];
  assign {bus.a_o, bus.b_o, bus.c_o, bus.d_o} = vec;
  assign bus.busy_o = state != IDLE;
  assign bus.done_o = state == DONE;
  assign bus.err_cnt_o = err_cnt;
  assign bus.glitch_cnt_o = glitch_cnt;
  assign bus.first_err_vec_o = fvec;
  assign bus.first_err_valid_o = fvalid;
  // next state; the first APPLY cycle after start only loads vector 0
  always_comb begin
    state_n = state;
    if (state == IDLE && bus.start_i) state_n = APPLY;
    if (state == APPLY && !pend) state_n = SETTLE;
    if (state == SETTLE && scnt == '0) state_n = CHECK;
    if (state == CHECK) state_n = idx == LAST_IDX ? DONE : APPLY;
    if (state == DONE) state_n = IDLE;
  end
  // state register plus run configuration, vector, settle tracking and result counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mode_q <= 1'b0;
      exp_q <= '0;
      pend <= 1'b0;
      idx <= '0;
      vec <= '0;
      y_prev <= 1'b0;
      tcnt <= '0;
      scnt <= '0;
      err_cnt <= '0;
      glitch_cnt <= '0;
      fvec <= '0;
      fvalid <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (bus.start_i) begin
          mode_q <= bus.mode_i;
          exp_q <= bus.expected_i;
          idx <= '0;
          pend <= 1'b1;
          err_cnt <= '0;
          glitch_cnt <= '0;
          fvec <= '0;
          fvalid <= 1'b0;
        end
        APPLY: if (pend) begin
          vec <= mode_q ? gray4(idx) : idx;
          pend <= 1'b0;
        end else begin
          y_prev <= bus.y_i;
          tcnt <= '0;
          scnt <= CW'(SETTLE_CYCLES - 1);
        end
        SETTLE: begin
          if (bus.y_i != y_prev && tcnt != 2'd3) tcnt <= tcnt + 2'd1;
          y_prev <= bus.y_i;
          scnt <= scnt - CW'(1);
        end
        CHECK: begin
          if (miss) err_cnt <= err_cnt + 5'd1;
          if (miss && !fvalid) begin
            fvec <= vec;
            fvalid <= 1'b1;
          end
          if (tcnt >= 2'd2) glitch_cnt <= glitch_cnt + 5'd1;
          if (idx != LAST_IDX) begin
            idx <= idx_n;
            vec <= mode_q ? gray4(idx_n) : idx_n;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/comb_vector_sequencer.md
# comb_vector_sequencer

Self-checking stimulus sequencer for a 4-input combinational block (inputs a, b, c, d; output y). On start it walks all 16 input vectors in binary or Gray order. After each vector it waits a settle window, then compares y against a 16-bit expected truth table. It counts mismatches and multi-transition (glitchy) settle windows. It sits beside the combinational datapath in lab/bring-up builds and replaces hand-written vector lists.

## Interface
Parameters:
- SETTLE_CYCLES, 4, cycles between applying a vector and checking y; must be ≥1, with an elaboration-time check.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, reset asynchronous, active-low
- start_i  in  1  begin a run; accepted only in IDLE
- mode_i  in  1  vector order: 0 = binary 0..15, 1 = Gray; latched at start
- expected_i  in  16  truth table; bit i = expected y for {a,b,c,d} = i (a is MSB); latched at start
- y_i  in  1  datapath output
- a_o, b_o, c_o, d_o  out  1 each  datapath inputs, driven from a registered vector
- busy_o  out  1  high from start acceptance through the DONE cycle
- done_o  out  1  one-cycle pulse at run end
- err_cnt_o  out  5  mismatch count, 0..16
- glitch_cnt_o  out  5  count of glitchy steps, 0..16
- first_err_vec_o  out  4  vector of the first mismatch
- first_err_valid_o  out  1  first_err_vec_o is meaningful

## Operation
- FSM states: IDLE, APPLY, SETTLE, CHECK, DONE.
- IDLE → APPLY on start_i.
  - At that edge: latch mode_i and expected_i; step index ← 0; clear err_cnt_o, glitch_cnt_o, first_err_vec_o and first_err_valid_o.
- APPLY (1 cycle): vector register ← step index in binary mode, or step index ^ (step index >> 1) in Gray mode. y_prev ← y_i. Go to SETTLE.
- SETTLE (SETTLE_CYCLES cycles):
  - Each cycle, if y_i ≠ y_prev, increment a 2-bit saturating transition counter; y_prev ← y_i.
  - The transition counter is cleared on entry to APPLY.
- CHECK (1 cycle): compare y_i with expected[vector].
  - On mismatch: err_cnt_o += 1. If first_err_valid_o is 0, capture the vector and set first_err_valid_o.
  - If the transition counter is ≥2, increment glitch_cnt_o.
  - If step index = 15, go to DONE; otherwise increment the step index and go to APPLY.
- DONE (1 cycle): done_o = 1, then go to IDLE.
- Result outputs hold after DONE until the next accepted start. a_o..d_o keep the last vector.
- start_i outside IDLE is ignored; no restart and no queuing.
- Counters cannot overflow, because there are at most 16 events.

## Timing
- Reset values: all outputs 0; vector 0; state IDLE; internal counters 0.
- Reset mid-run aborts immediately. After release the block is in IDLE with all outputs 0. No done_o is produced for the aborted run.
- Number the clock edges so that start_i is sampled high at edge 0:
  - APPLY for step k is entered at edge 1 + k·(SETTLE_CYCLES+2); a_o..d_o change at that edge.
  - CHECK for step k occupies the cycle after edge (k+1)·(SETTLE_CYCLES+2).
  - done_o is high in the cycle after edge 16·(SETTLE_CYCLES+2)+1. With the default parameter this is edge 97.
- busy_o rises at edge 0 and falls at the edge leaving DONE.
- y_i is sampled synchronously with no synchronizer, because the datapath is combinational from registered outputs. Transitions are counted at cycle granularity only.

## Structure
- Shared package comb_seq_pkg:
  - state_t enum;
  - localparam NUM_VEC = 16;
  - function gray4 (4-bit binary to Gray).
- No sub-module. Single module; counters and FSM in one always_ff with an asynchronous-low reset.

## Test plan
Reference model for the bench: y = (a&b)|(c&d), expected table 0xF888.
- Reset: assert rst_n=0 -> every output 0, busy_o=0.
- Binary run, SETTLE_CYCLES=4, expected 0xF888 -> a_o..d_o step 0,1,..,15; done_o pulses at edge 97; err_cnt_o=0, glitch_cnt_o=0, first_err_valid_o=0.
- Expected 0xF889, binary run -> err_cnt_o=1, first_err_vec_o=0, first_err_valid_o=1.
- Gray run, expected 0xF888 -> vector order 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8; err_cnt_o=0.
- Glitch injection: force y to toggle twice during the settle window of vector 5 but settle correctly -> glitch_cnt_o=1, err_cnt_o=0.
- Reset and start-ignore:
  - pulse start_i again during step 3 -> ignored; the run completes once, with one done_o.
  - drop rst_n during step 7 -> all outputs 0 and IDLE; no done_o.
  - a new start then gives a full clean run.
